// File: rtl/pokemon_pkg.sv
// Shared constants and helpers for the Pokemon arena blocks.
package pokemon_pkg;

    localparam int unsigned SCREEN_W     = 96;
    localparam int unsigned SCREEN_H     = 64;
    localparam int unsigned X_W          = 7;
    localparam int unsigned Y_W          = 6;

    localparam int unsigned SLOTS_DEF    = 12;
    localparam int unsigned STEP_DEF     = 2;
    localparam int unsigned COOLDOWN_DEF = 8;

    // Widest slot_x bus the unpack helper accepts; narrower buses are zero-extended.
    localparam int unsigned MAX_SLOTS    = 32;
    localparam int unsigned BUS_MAX      = X_W * MAX_SLOTS;

    // Extract slot i's leftX from a packed slot_x bus.
    function automatic logic [X_W-1:0] slot_x_of(input logic [BUS_MAX-1:0] vec,
                                                  input int unsigned        i);
        return vec[X_W*i +: X_W];
    endfunction

endpackage

// File: rtl/lowest_free_slot.sv
// Priority encoder: index of the lowest slot whose enable is clear.
module lowest_free_slot
    import pokemon_pkg::*;
#(
    parameter int unsigned SLOTS = SLOTS_DEF
) (
    input  logic [SLOTS-1:0]                           i_slot_en,
    output logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0] o_idx_c,
    output logic                                       o_any_free_c
);

    localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    // Scan high to low so the lowest free index is the last one written.
    always_comb begin
        o_idx_c      = '0;
        o_any_free_c = 1'b0;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (!i_slot_en[i]) begin
                o_idx_c      = IDX_W'(i);
                o_any_free_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// One player's projectile slots: spawn on shoot edge, move per tick, retire on exit or hit.
module projectile_pool
    import pokemon_pkg::*;
#(
    parameter int unsigned    SLOTS    = SLOTS_DEF,
    parameter bit             DIR      = 1'b0,
    parameter logic [X_W-1:0] X_SPAWN  = 7'd22,
    parameter logic [X_W-1:0] X_LIMIT  = 7'd90,
    parameter int unsigned    STEP     = STEP_DEF,
    parameter int unsigned    COOLDOWN = COOLDOWN_DEF
) (
    input  logic                 clk_50Hz,
    input  logic                 reset_n,
    input  logic                 shoot,
    input  logic                 shooter_alive,
    input  logic [SLOTS-1:0]     hit_clear,
    output logic [SLOTS-1:0]     slot_en,
    output logic [X_W*SLOTS-1:0] slot_x,
    output logic                 shot_fired,
    output logic                 shot_dropped,
    output logic [7:0]           shots_total
);

    localparam int unsigned IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [7:0]  STEP8  = 8'(STEP);
    localparam logic [7:0]  LIMIT8 = {1'b0, X_LIMIT};

    logic [SLOTS-1:0] r_slot_en;
    logic [X_W-1:0]   r_x [SLOTS];
    logic             r_fired;
    logic             r_dropped;
    logic [7:0]       r_total;
    logic [CD_W-1:0]  r_cd;
    logic             r_shoot_q;

    logic [SLOTS-1:0] w_slot_en_n;
    logic [X_W-1:0]   w_x_n [SLOTS];
    logic             w_fired_n;
    logic             w_dropped_n;
    logic [7:0]       w_total_n;
    logic [CD_W-1:0]  w_cd_n;

    logic [IDX_W-1:0] w_idx;
    logic             w_any_free;
    logic             w_req;
    logic             w_accept;
    logic [7:0]       w_cur;
    logic [7:0]       w_next;
    logic             w_exit;

    // Allocation is judged on the registered enables, so slots retiring this cycle stay busy.
    lowest_free_slot #(
        .SLOTS (SLOTS)
    ) u_free (
        .i_slot_en    (r_slot_en),
        .o_idx_c      (w_idx),
        .o_any_free_c (w_any_free)
    );

    assign w_req    = shoot & ~r_shoot_q;
    assign w_accept = w_req & shooter_alive & (r_cd == '0);

    // Next-state: movement, exits and clears first, then spawn into a free slot.
    always_comb begin
        w_slot_en_n = r_slot_en;
        w_x_n       = r_x;
        w_fired_n   = 1'b0;
        w_dropped_n = 1'b0;
        w_total_n   = r_total;
        w_cd_n      = (r_cd != '0) ? (r_cd - CD_W'(1)) : r_cd;
        w_cur       = '0;
        w_next      = '0;
        w_exit      = 1'b0;

        for (int i = 0; i < int'(SLOTS); i++) begin
            if (r_slot_en[i]) begin
                if (hit_clear[i]) begin
                    w_slot_en_n[i] = 1'b0;
                end else begin
                    w_cur = {1'b0, r_x[i]};
                    if (DIR == 1'b0) begin
                        w_next = w_cur + STEP8;
                        w_exit = (w_next > LIMIT8);
                    end else begin
                        w_next = w_cur - STEP8;
                        w_exit = (w_cur < STEP8) || (w_next < LIMIT8);
                    end
                    if (w_exit) begin
                        w_slot_en_n[i] = 1'b0;
                    end else begin
                        w_x_n[i] = w_next[X_W-1:0];
                    end
                end
            end
        end

        if (w_accept) begin
            if (w_any_free) begin
                w_slot_en_n[w_idx] = 1'b1;
                w_x_n[w_idx]       = X_SPAWN;
                w_cd_n             = CD_W'(COOLDOWN);
                w_fired_n          = 1'b1;
                w_total_n          = r_total + 8'd1;
            end else begin
                w_dropped_n = 1'b1;
            end
        end
    end

    // State register; edge detector resets high so a held button does not fire.
    always_ff @(posedge clk_50Hz or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_en <= '0;
            r_x       <= '{default: '0};
            r_fired   <= 1'b0;
            r_dropped <= 1'b0;
            r_total   <= '0;
            r_cd      <= '0;
            r_shoot_q <= 1'b1;
        end else begin
            r_slot_en <= w_slot_en_n;
            r_x       <= w_x_n;
            r_fired   <= w_fired_n;
            r_dropped <= w_dropped_n;
            r_total   <= w_total_n;
            r_cd      <= w_cd_n;
            r_shoot_q <= shoot;
        end
    end

    // Pack per-slot leftX onto the renderer bus.
    always_comb begin
        slot_x = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            slot_x[X_W*i +: X_W] = r_x[i];
        end
    end

    assign slot_en      = r_slot_en;
    assign shot_fired   = r_fired;
    assign shot_dropped = r_dropped;
    assign shots_total  = r_total;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: default, fill-friendly and DIR=1 instances.
module tb_projectile_pool;
    import pokemon_pkg::*;

    logic clk_50Hz = 1'b0;
    logic reset_n  = 1'b0;

    // Instance A: defaults
    logic        a_shoot = 1'b0, a_alive = 1'b1;
    logic [11:0] a_hit = '0, a_en;
    logic [83:0] a_x;
    logic        a_fired, a_dropped;
    logic [7:0]  a_total;

    // Instance B: slow, long arena so all 12 slots can be in flight
    logic        b_shoot = 1'b0, b_alive = 1'b1;
    logic [11:0] b_hit = '0, b_en;
    logic [83:0] b_x;
    logic        b_fired, b_dropped;
    logic [7:0]  b_total;

    // Instance C: DIR=1 toward X=0
    logic        c_shoot = 1'b0, c_alive = 1'b1;
    logic [11:0] c_hit = '0, c_en;
    logic [83:0] c_x;
    logic        c_fired, c_dropped;
    logic [7:0]  c_total;

    int n_checks = 0;
    int n_err    = 0;

    projectile_pool u_a (
        .clk_50Hz(clk_50Hz), .reset_n(reset_n), .shoot(a_shoot), .shooter_alive(a_alive),
        .hit_clear(a_hit), .slot_en(a_en), .slot_x(a_x), .shot_fired(a_fired),
        .shot_dropped(a_dropped), .shots_total(a_total));

    projectile_pool #(.SLOTS(12), .DIR(1'b0), .X_SPAWN(7'd0), .X_LIMIT(7'd127),
                      .STEP(1), .COOLDOWN(2)) u_b (
        .clk_50Hz(clk_50Hz), .reset_n(reset_n), .shoot(b_shoot), .shooter_alive(b_alive),
        .hit_clear(b_hit), .slot_en(b_en), .slot_x(b_x), .shot_fired(b_fired),
        .shot_dropped(b_dropped), .shots_total(b_total));

    projectile_pool #(.SLOTS(12), .DIR(1'b1), .X_SPAWN(7'd66), .X_LIMIT(7'd0),
                      .STEP(2), .COOLDOWN(8)) u_c (
        .clk_50Hz(clk_50Hz), .reset_n(reset_n), .shoot(c_shoot), .shooter_alive(c_alive),
        .hit_clear(c_hit), .slot_en(c_en), .slot_x(c_x), .shot_fired(c_fired),
        .shot_dropped(c_dropped), .shots_total(c_total));

    always #5 clk_50Hz = ~clk_50Hz;

    function automatic logic [6:0] xa(input int unsigned i);
        return slot_x_of(BUS_MAX'(a_x), i);
    endfunction
    function automatic logic [6:0] xb(input int unsigned i);
        return slot_x_of(BUS_MAX'(b_x), i);
    endfunction
    function automatic logic [6:0] xc(input int unsigned i);
        return slot_x_of(BUS_MAX'(c_x), i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, returning 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_50Hz);
        #1;
    endtask

    initial begin
        // Reset with A's button held down
        a_shoot = 1'b1;
        #1;
        chk("rst_en",      32'(a_en), 0);
        chk("rst_x_any",   32'(a_x != '0), 0);
        chk("rst_fired",   32'(a_fired), 0);
        chk("rst_dropped", 32'(a_dropped), 0);
        chk("rst_total",   32'(a_total), 0);
        #11 reset_n = 1'b1;
        step(2);
        chk("held_no_fire_en", 32'(a_en), 0);
        chk("held_no_fire_total", 32'(a_total), 0);

        // A: first spawn (E1)
        a_shoot = 1'b0; step(1);
        a_shoot = 1'b1; step(1);
        chk("spawn_en",    32'(a_en), 32'h001);
        chk("spawn_x0",    32'(xa(0)), 22);
        chk("spawn_fired", 32'(a_fired), 1);
        chk("spawn_total", 32'(a_total), 1);
        a_shoot = 1'b0; step(1);
        chk("fired_pulse_end", 32'(a_fired), 0);
        chk("move_x0_e2",  32'(xa(0)), 24);
        // Edge 3 cycles after spawn is inside cooldown (E4)
        step(1);
        a_shoot = 1'b1; step(1);
        chk("cd_reject_en",    32'(a_en), 32'h001);
        chk("cd_reject_total", 32'(a_total), 1);
        chk("cd_reject_x0",    32'(xa(0)), 28);
        // Edge once cooldown has expired (E10)
        a_shoot = 1'b0; step(5);
        a_shoot = 1'b1; step(1);
        chk("cd_ok_en",    32'(a_en), 32'h003);
        chk("cd_ok_x1",    32'(xa(1)), 22);
        chk("cd_ok_x0",    32'(xa(0)), 40);
        chk("cd_ok_total", 32'(a_total), 2);
        a_shoot = 1'b0;
        // Slot 0 reaches X_LIMIT then retires (E35, E36)
        step(25);
        chk("limit_x0", 32'(xa(0)), 90);
        chk("limit_en", 32'(a_en), 32'h003);
        step(1);
        chk("exit_en", 32'(a_en), 32'h002);
        chk("exit_x0_hold", 32'(xa(0)), 90);
        chk("exit_x1", 32'(xa(1)), 74);
        // Shooter dead: no spawn, no cooldown, flight continues (E37)
        a_alive = 1'b0; a_shoot = 1'b1; step(1);
        chk("dead_en",    32'(a_en), 32'h002);
        chk("dead_total", 32'(a_total), 2);
        chk("dead_fired", 32'(a_fired), 0);
        chk("dead_x1",    32'(xa(1)), 76);
        a_alive = 1'b1; a_shoot = 1'b0; step(1);
        a_shoot = 1'b1; step(1);
        chk("alive_again_en", 32'(a_en), 32'h003);
        chk("alive_again_x0", 32'(xa(0)), 22);
        chk("alive_again_x1", 32'(xa(1)), 80);
        chk("alive_again_total", 32'(a_total), 3);
        a_shoot = 1'b0;

        // B: fill all 12 slots with edges 3 ticks apart (F0..F35)
        for (int k = 0; k < 12; k++) begin
            b_shoot = 1'b1; step(1);
            chk("fill_en", 32'(b_en), 32'((1 << (k + 1)) - 1));
            b_shoot = 1'b0; step(2);
        end
        chk("fill_total", 32'(b_total), 12);
        chk("fill_x0",    32'(xb(0)), 35);
        // One more edge with no free slot (F36)
        b_shoot = 1'b1; step(1);
        chk("full_dropped", 32'(b_dropped), 1);
        chk("full_fired",   32'(b_fired), 0);
        chk("full_en",      32'(b_en), 32'hFFF);
        chk("full_total",   32'(b_total), 12);
        b_shoot = 1'b0; step(1);
        chk("dropped_pulse_end", 32'(b_dropped), 0);
        // Clear slot 2 with an accepted edge; no cooldown was loaded by the drop (F38)
        b_shoot = 1'b1; b_hit = 12'h004; step(1);
        chk("clr_dropped", 32'(b_dropped), 1);
        chk("clr_en",      32'(b_en), 32'hFFB);
        chk("clr_x2_hold", 32'(xb(2)), 31);
        b_shoot = 1'b0; b_hit = '0; step(1);
        b_shoot = 1'b1; step(1);
        chk("reuse_en",    32'(b_en), 32'hFFF);
        chk("reuse_x2",    32'(xb(2)), 0);
        chk("reuse_fired", 32'(b_fired), 1);
        chk("reuse_total", 32'(b_total), 13);
        b_shoot = 1'b0;

        // C: DIR=1 runs 66 down to 0 and retires without wrapping (G0..G34)
        c_shoot = 1'b1; step(1);
        chk("neg_spawn_en", 32'(c_en), 32'h001);
        chk("neg_spawn_x0", 32'(xc(0)), 66);
        c_shoot = 1'b0; step(32);
        chk("neg_x0_2", 32'(xc(0)), 2);
        step(1);
        chk("neg_x0_0", 32'(xc(0)), 0);
        chk("neg_en_at_0", 32'(c_en), 32'h001);
        step(1);
        chk("neg_exit_en", 32'(c_en), 32'h000);
        chk("neg_exit_x0", 32'(xc(0)), 0);
        c_shoot = 1'b1; step(1);
        chk("neg_respawn_en", 32'(c_en), 32'h001);
        c_shoot = 1'b0;

        // Asynchronous reset mid-flight, away from any clock edge
        chk("pre_rst_b_en", 32'(b_en), 32'hFFF);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_b_en",    32'(b_en), 0);
        chk("arst_b_x_any", 32'(b_x != '0), 0);
        chk("arst_b_total", 32'(b_total), 0);
        chk("arst_c_en",    32'(c_en), 0);
        chk("arst_c_x_any", 32'(c_x != '0), 0);
        chk("arst_a_total", 32'(a_total), 0);
        #3 reset_n = 1'b1;
        step(2);
        chk("post_rst_a_en", 32'(a_en), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
